pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 6-slot register chain PC/IF/ID/EX/MEM/WB.
//  Merges per-stage stall requests into stall_o[5:0], which drives every pipeline register.
//  Turns MEM-stage exceptions into a one-cycle flush_o plus a redirect PC.
//  Masks re-triggering for a fixed window after each flush, and counts stalled cycles.
// PARAMETERS
//  EXC_VECTOR   32'h0000_0020  redirect PC for every exception except ERET
//  ERET_CODE    32'h0000_000e  excepttype_i value that selects cp0_epc_i
//  MASK_CYC     2              cycles after a flush during which excepttype_i is ignored (>=1)
//  WDOG_LIMIT   1024           consecutive stalled cycles that fire wdog_o (macro build only)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous reset, active-low
//  stallreq_if_i   in   1   fetch stage waits on instruction bus
//  stallreq_id_i   in   1   decode load-use hazard
//  stallreq_ex_i   in   1   multi-cycle mult/div busy
//  stallreq_mem_i  in   1   data bus wait
//  excepttype_i    in   32  exception code from MEM; 0 = none
//  cp0_epc_i       in   32  current EPC (already forwarded)
//  stall_o         out  6   bit0=PC ... bit5=WB; 1 = hold that register
//  flush_o         out  1   clear all pipeline registers this edge
//  new_pc_o        out  32  redirect target; valid only while flush_o=1, else 0
//  stall_cycles_o  out  32  saturating count of cycles with stall_o!=0
//  wdog_o          out  1   one-cycle pulse on stall watchdog expiry
// BEHAVIOUR
//  - Reset (rst=0, async): state=RUN, mask_cnt=0, stall_cycles_o=0, wdog counter=0, wdog_o=0.
//    stall_o, flush_o and new_pc_o evaluate to 0 while in reset.
//  - Stall encode (combinational, deepest request wins):
//    mem->6'b011111, ex->6'b001111, id->6'b000111, if->6'b000011, none->6'b000000.
//  - FSM RUN: if excepttype_i!=0, then in the same cycle:
//    flush_o=1, stall_o=0, new_pc_o=(excepttype_i==ERET_CODE)?cp0_epc_i:EXC_VECTOR.
//    Next state MASK, mask_cnt<=MASK_CYC-1. Otherwise stall_o=encode(reqs).
//  - FSM MASK: excepttype_i ignored, flush_o=0, stall_o=encode(reqs).
//    mask_cnt decrements every cycle, including stalled cycles; at 0 the next state is RUN.
//  - Exception and stall request in the same RUN cycle: flush wins, stall_o=0, no count.
//  - Exception arriving in the last MASK cycle is dropped; the source must hold it to retry.
//  - stall_cycles_o: +1 on each edge where stall_o!=0; holds at 32'hFFFF_FFFF; cleared by reset only.
//  - Outputs stall_o, flush_o and new_pc_o are combinational from state and inputs (0 latency).
//    stall_cycles_o and wdog_o are registered.
//  - Reset asserted in MASK returns to RUN; a flush in progress is abandoned.
// CONFIGURATION
//  Macro HAZARD_CTRL_STALL_WDOG_EN:
//  - Defined: counter of consecutive stall_o!=0 cycles, cleared by any non-stall or flush cycle.
//    On reaching WDOG_LIMIT, wdog_o=1 for one cycle and the counter restarts at 0.
//  - Undefined: no counter; wdog_o tied 1'b0; port list unchanged.
// STRUCTURE
//  - Package pipe_ctrl_pkg: stall encodings (STALL_NONE/IF/ID/EX/MEM), FSM state enum {RUN,MASK},
//    ERET_CODE default, stall-vector width 6.
//  - Sub-module pipe_stall_encoder: pure combinational 4-request -> 6-bit stall priority encoder.
//    The FSM, counters and redirect mux stay in pipe_hazard_ctrl.
// TESTING
//  - stallreq_id_i=1 alone, 3 cycles -> stall_o=6'b000111 each cycle; stall_cycles_o=3 after.
//  - id+mem requests together -> stall_o=6'b011111.
//  - excepttype_i=32'h8 with stallreq_ex_i=1 -> flush_o=1, stall_o=0, new_pc_o=32'h20;
//    stall_cycles_o unchanged.
//  - excepttype_i=32'he, cp0_epc_i=32'h1234 -> new_pc_o=32'h1234 for 1 cycle.
//    A repeat excepttype_i on the next 2 cycles is ignored (MASK_CYC=2); a repeat on the 3rd cycle flushes.
//  - Force stall_cycles_o to 32'hFFFF_FFFE, hold stall 3 cycles -> reads 32'hFFFF_FFFF.
//    rst=0 mid-MASK -> all outputs 0, state RUN.
//  - With macro, WDOG_LIMIT=4, continuous stallreq_mem_i -> wdog_o pulses on cycles 4, 8, ...
//    Without macro, wdog_o stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   STALL_W / stall_t : width and type of the six-slot stall vector (bit0=PC ... bit5=WB)
//   STALL_*           : stall encodings, one per requesting stage
//   state_e           : sequencer states RUN / MASK
//   ERET_CODE_DEF     : default exception code that redirects to EPC
//   EXC_VECTOR_DEF    : default redirect target for all other exceptions
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_t;

  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_IF   = 6'b000011;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MASK = 1'b1
  } state_e;

  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline stages and the hazard controller.
//   stallreq_*_i   : per-stage stall requests (IF, ID, EX, MEM)
//   excepttype_i   : MEM-stage exception code, 0 = none
//   cp0_epc_i      : forwarded EPC used as the ERET target
//   stall_o        : hold mask for the six pipeline registers
//   flush_o        : clear all pipeline registers this edge
//   new_pc_o       : redirect target, valid only with flush_o
//   stall_cycles_o : saturating stalled-cycle count
//   wdog_o         : stall watchdog pulse
// Modports: master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  stall_t      stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cycles_o;
  logic        wdog_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output excepttype_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, stall_cycles_o, wdog_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  excepttype_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, stall_cycles_o, wdog_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_encoder.sv
// Combinational priority encoder: four stage stall requests -> six-bit stall vector.
// The deepest requesting stage wins, since it must also hold every earlier stage.
//   req_if_i, req_id_i, req_ex_i, req_mem_i : stall requests
//   stall_o                                 : encoded stall vector
module pipe_stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic   req_if_i,
  input  logic   req_id_i,
  input  logic   req_ex_i,
  input  logic   req_mem_i,
  output stall_t stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (req_mem_i)     stall_o = STALL_MEM;
    else if (req_ex_i) stall_o = STALL_EX;
    else if (req_id_i) stall_o = STALL_ID;
    else if (req_if_i) stall_o = STALL_IF;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the PC/IF/ID/EX/MEM/WB register chain.
// Merges stall requests, turns MEM exceptions into a one-cycle flush with a redirect PC,
// ignores exceptions for MASK_CYC cycles after each flush, and counts stalled cycles.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : pipe_hazard_ctrl_if.slave (requests, exception inputs, stall/flush/redirect outputs)
// Optional build macro HAZARD_CTRL_STALL_WDOG_EN adds a consecutive-stall watchdog
// driving wdog_o; without it wdog_o is tied low.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
  parameter int unsigned MASK_CYC   = 2,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned MW = (MASK_CYC > 1) ? $clog2(MASK_CYC) : 1;

  stall_t         stall_req;
  stall_t         stall;
  logic           flush;
  logic [31:0]    new_pc;
  state_e         state_q, state_d;
  logic [MW-1:0]  mask_cnt_q, mask_cnt_d;
  logic [31:0]    stall_cycles_q;

  pipe_stall_encoder u_enc (
    .req_if_i  (bus.stallreq_if_i),
    .req_id_i  (bus.stallreq_id_i),
    .req_ex_i  (bus.stallreq_ex_i),
    .req_mem_i (bus.stallreq_mem_i),
    .stall_o   (stall_req)
  );

  // Outputs are forced low while rst is held so the pipeline sees no stray flush.
  always_comb begin
    state_d    = state_q;
    mask_cnt_d = mask_cnt_q;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = '0;
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.excepttype_i != '0) begin
            flush      = 1'b1;
            new_pc     = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
            state_d    = MASK;
            mask_cnt_d = MW'(MASK_CYC - 1);
          end else begin
            stall = stall_req;
          end
        end
        MASK: begin
          stall = stall_req;
          if (mask_cnt_q == '0) state_d = RUN;
          else                  mask_cnt_d = mask_cnt_q - MW'(1);
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      mask_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_cnt_q <= mask_cnt_d;
      if (stall != STALL_NONE && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.new_pc_o       = new_pc;
  assign bus.stall_cycles_o = stall_cycles_q;

`ifdef HAZARD_CTRL_STALL_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_q;

  // Flush cycles always carry stall=0, so they clear the run length too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else if (stall == STALL_NONE) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else if (wdog_cnt_q == 32'(WDOG_LIMIT - 1)) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b1;
    end else begin
      wdog_cnt_q <= wdog_cnt_q + 32'd1;
      wdog_q     <= 1'b0;
    end
  end

  assign bus.wdog_o = wdog_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_LIMIT == 0);
  assign bus.wdog_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int unsigned WDOG = 4;

  typedef struct {
    string       nm;
    logic [3:0]  req;    // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt = '0;
  int unsigned wd_cnt = 0;
  logic        exp_wd = 1'b0;
  vec_t vecs[13];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .ERET_CODE  (32'h0000_000e),
    .MASK_CYC   (2),
    .WDOG_LIMIT (WDOG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts and ends at a falling edge; one clock cycle per call.
  task automatic cycle(input string nm, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic [5:0] es, input logic ef,
                       input logic [31:0] epc_exp);
    {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i} = req;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    #2;
    chk({nm, ".stall"}, 32'(bus.stall_o), 32'(es));
    chk({nm, ".flush"}, 32'(bus.flush_o), 32'(ef));
    chk({nm, ".new_pc"}, bus.new_pc_o, epc_exp);
    @(posedge clk);
    if (es != 6'd0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
`ifdef HAZARD_CTRL_STALL_WDOG_EN
    if (es != 6'd0) begin
      if (wd_cnt == WDOG - 1) begin wd_cnt = 0; exp_wd = 1'b1; end
      else begin wd_cnt++; exp_wd = 1'b0; end
    end else begin
      wd_cnt = 0; exp_wd = 1'b0;
    end
`else
    exp_wd = 1'b0;
`endif
    @(negedge clk);
    chk({nm, ".stall_cycles"}, bus.stall_cycles_o, exp_cnt);
    chk({nm, ".wdog"}, 32'(bus.wdog_o), 32'(exp_wd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle", 4'b0000, '0, '0, 6'b0, 1'b0, '0);
  endtask

  initial begin
    vecs[0]  = '{"none",     4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h0};
    vecs[1]  = '{"if",       4'b0001, 32'h0, 32'h0,    6'b000011, 1'b0, 32'h0};
    vecs[2]  = '{"id",       4'b0010, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0};
    vecs[3]  = '{"ex",       4'b0100, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0};
    vecs[4]  = '{"mem",      4'b1000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    vecs[5]  = '{"id_mem",   4'b1010, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    vecs[6]  = '{"if_ex",    4'b0101, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0};
    vecs[7]  = '{"if_id",    4'b0011, 32'h0, 32'h0,    6'b000111, 1'b0, 32'h0};
    vecs[8]  = '{"all",      4'b1111, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h0};
    vecs[9]  = '{"exc8_ex",  4'b0100, 32'h8, 32'h0,    6'b000000, 1'b1, 32'h20};
    vecs[10] = '{"eret",     4'b0000, 32'he, 32'h1234, 6'b000000, 1'b1, 32'h1234};
    vecs[11] = '{"eret_mem", 4'b1000, 32'he, 32'habcd, 6'b000000, 1'b1, 32'habcd};
    vecs[12] = '{"exc1",     4'b0000, 32'h1, 32'h5555, 6'b000000, 1'b1, 32'h20};

    // Reset with live requests and an exception: everything must read 0.
    rst = 1'b0;
    {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i} = 4'b1111;
    bus.excepttype_i = 32'h8;
    bus.cp0_epc_i    = 32'h1234;
    #2;
    chk("rst.stall", 32'(bus.stall_o), 32'h0);
    chk("rst.flush", 32'(bus.flush_o), 32'h0);
    chk("rst.new_pc", bus.new_pc_o, 32'h0);
    chk("rst.stall_cycles", bus.stall_cycles_o, 32'h0);
    chk("rst.wdog", 32'(bus.wdog_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) cycle("id_hold", 4'b0010, '0, '0, 6'b000111, 1'b0, '0);
    chk("id_hold.count3", bus.stall_cycles_o, 32'd3);

    foreach (vecs[i]) begin
      cycle(vecs[i].nm, vecs[i].req, vecs[i].exc, vecs[i].epc,
            vecs[i].stall, vecs[i].flush, vecs[i].pc);
      if (vecs[i].flush) idle(3);
    end

    // Held ERET: flushes once, ignored for two cycles (stall still honoured), then flushes again.
    cycle("mask0", 4'b0000, 32'he, 32'h1234, 6'b000000, 1'b1, 32'h1234);
    cycle("mask1", 4'b0010, 32'he, 32'h1234, 6'b000111, 1'b0, 32'h0);
    cycle("mask2", 4'b0000, 32'he, 32'h1234, 6'b000000, 1'b0, 32'h0);
    cycle("mask3", 4'b0000, 32'he, 32'h1234, 6'b000000, 1'b1, 32'h1234);
    idle(3);

    // Saturation.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    exp_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle("sat", 4'b1000, '0, '0, 6'b011111, 1'b0, '0);
    chk("sat.final", bus.stall_cycles_o, 32'hFFFF_FFFF);

    // Watchdog run (model pulses every WDOG stalled cycles only in the macro build).
    idle(1);
    for (int i = 0; i < 9; i++) cycle("wdog_run", 4'b1000, '0, '0, 6'b011111, 1'b0, '0);
    idle(1);

    // Reset asserted mid-MASK.
    cycle("pre_rst_flush", 4'b0000, 32'h8, '0, 6'b0, 1'b1, 32'h20);
    {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i} = 4'b1111;
    bus.excepttype_i = 32'h8;
    rst = 1'b0;
    #2;
    chk("mid_rst.stall", 32'(bus.stall_o), 32'h0);
    chk("mid_rst.flush", 32'(bus.flush_o), 32'h0);
    chk("mid_rst.new_pc", bus.new_pc_o, 32'h0);
    chk("mid_rst.stall_cycles", bus.stall_cycles_o, 32'h0);
    chk("mid_rst.wdog", 32'(bus.wdog_o), 32'h0);
    exp_cnt = '0;
    wd_cnt  = 0;
    exp_wd  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle("post_rst_flush", 4'b0100, 32'h8, '0, 6'b0, 1'b1, 32'h20);
    idle(3);
    cycle("post_rst_stall", 4'b0001, '0, '0, 6'b000011, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
